// File: rtl/pht_update_queue_pkg.sv
// Fetch-unit shared types: branch results, PHT entry/index types, the
// update-queue entry layout and the index/counter helper functions.
package FetchUnitTypes;

    localparam int INSN_ADDR_BIT_WIDTH             = 2;
    localparam int ADDR_WIDTH                      = 32;
    localparam int PHT_ENTRY_NUM_BIT_WIDTH         = 10;
    localparam int BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 8;
    localparam int PHT_QUEUE_SIZE                  = 32;
    localparam int PHT_QUEUE_SIZE_BIT_WIDTH        = $clog2(PHT_QUEUE_SIZE);

    typedef logic [1:0]                                   PHT_EntryPath;
    typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]           PHT_IndexPath;
    typedef logic [BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0]   BranchGlobalHistoryPath;
    typedef logic [ADDR_WIDTH-1:0]                        AddrPath;
    typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH-1:0]          PhtQueuePointerPath;

    localparam PHT_EntryPath PHT_ENTRY_MAX = 2'd3;

    typedef struct packed {
        logic                   valid;
        logic                   isCondBr;
        logic                   execTaken;
        AddrPath                brAddr;
        BranchGlobalHistoryPath globalHistory;
        PHT_EntryPath           phtPrevValue;
    } BranchResult;

    typedef struct packed {
        logic         phtWE;
        PHT_IndexPath phtWA;
        PHT_EntryPath phtWV;
    } PhtQueueEntry;

    // Gshare-style index: word address bits XOR zero-extended global history.
    function automatic PHT_IndexPath ToPHT_Index(input AddrPath addr,
                                                 input BranchGlobalHistoryPath gh);
        return addr[PHT_ENTRY_NUM_BIT_WIDTH+INSN_ADDR_BIT_WIDTH-1:INSN_ADDR_BIT_WIDTH]
               ^ PHT_IndexPath'(gh);
    endfunction

    // Saturating 2-bit counter step up.
    function automatic PHT_EntryPath IncrementPHT_Counter(input PHT_EntryPath v);
        return (v == PHT_ENTRY_MAX) ? v : v + 2'd1;
    endfunction

    // Saturating 2-bit counter step down.
    function automatic PHT_EntryPath DecrementPHT_Counter(input PHT_EntryPath v);
        return (v == 2'd0) ? v : v - 2'd1;
    endfunction

endpackage

// File: rtl/pht_update_queue_ram.sv
// Queue storage: one synchronous write port, one asynchronous read port so
// the head entry is visible in the same cycle the PHT write happens.
module pht_update_queue_ram
    import FetchUnitTypes::*;
#(
    parameter int ENTRY_NUM       = PHT_QUEUE_SIZE,
    parameter int INDEX_BIT_WIDTH = $clog2(PHT_QUEUE_SIZE)
)(
    input  logic                       clk,
    input  logic                       we,
    input  logic [INDEX_BIT_WIDTH-1:0] wa,
    input  PhtQueueEntry               wv,
    input  logic [INDEX_BIT_WIDTH-1:0] ra,
    output PhtQueueEntry               rv
);

    PhtQueueEntry array [ENTRY_NUM];

    // Write the tail entry; contents need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            array[wa] <= wv;
        end
    end

    // Head entry read out combinationally.
    always_comb begin
        rv = array[ra];
    end

endmodule

// File: rtl/pht_update_queue.sv
// Buffers PHT counter updates from executed conditional branches and
// drains them into the single-port PHT whenever the predictor is not
// reading it. Saturated (no-change) updates are filtered out; updates that
// find the queue full are dropped and flagged for one cycle.
module pht_update_queue
    import FetchUnitTypes::*;
#(
    parameter int QUEUE_SIZE    = PHT_QUEUE_SIZE,        // power of two >= 2
    parameter int PHT_IDX_WIDTH = PHT_ENTRY_NUM_BIT_WIDTH // <= PHT_ENTRY_NUM_BIT_WIDTH
)(
    input  logic                          clk,
    input  logic                          rst,
    input  BranchResult                   brResult,
    input  logic                          phtReadReq,
    output logic                          phtWE,
    output logic [PHT_IDX_WIDTH-1:0]      phtWA,
    output PHT_EntryPath                  phtWV,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(QUEUE_SIZE):0]   count,
    output logic                          dropped
);

    localparam int PTR_WIDTH = $clog2(QUEUE_SIZE);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(QUEUE_SIZE);

    logic [PTR_WIDTH-1:0] headPtr;
    logic [PTR_WIDTH-1:0] tailPtr;
    logic [CNT_WIDTH-1:0] occupancy;

    PHT_EntryPath newValue;
    PHT_IndexPath fullIndex;
    PhtQueueEntry newEntry;
    PhtQueueEntry headEntry;
    logic         needsWrite;
    logic         doDeq;
    logic         doEnq;

    // Status flags come straight from the registered occupancy.
    always_comb begin
        count = occupancy;
        empty = (occupancy == '0);
        full  = (occupancy == FULL_COUNT);
    end

    // Build the candidate entry and decide enqueue / dequeue / drop.
    always_comb begin
        newValue  = brResult.execTaken ? IncrementPHT_Counter(brResult.phtPrevValue)
                                       : DecrementPHT_Counter(brResult.phtPrevValue);
        fullIndex = ToPHT_Index(brResult.brAddr, brResult.globalHistory);

        newEntry       = '0;
        newEntry.phtWE = 1'b1;
        newEntry.phtWA = PHT_IndexPath'(fullIndex[PHT_IDX_WIDTH-1:0]);
        newEntry.phtWV = newValue;

        // Saturated counters would rewrite the same value, so skip them.
        needsWrite = brResult.valid && brResult.isCondBr &&
                     (newValue != brResult.phtPrevValue);
        doDeq      = !rst && !empty && !phtReadReq;
        doEnq      = !rst && needsWrite && (!full || doDeq);
        dropped    = !rst && needsWrite && !doEnq;

        phtWE = doDeq;
        phtWA = headEntry.phtWA[PHT_IDX_WIDTH-1:0];
        phtWV = headEntry.phtWV;
    end

    // Pointer and occupancy bookkeeping; pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
        end else begin
            if (doDeq) begin
                headPtr <= headPtr + 1'b1;
            end
            if (doEnq) begin
                tailPtr <= tailPtr + 1'b1;
            end
            if (doEnq && !doDeq) begin
                occupancy <= occupancy + 1'b1;
            end else if (doDeq && !doEnq) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    pht_update_queue_ram #(
        .ENTRY_NUM       (QUEUE_SIZE),
        .INDEX_BIT_WIDTH (PTR_WIDTH)
    ) ram (
        .clk (clk),
        .we  (doEnq),
        .wa  (tailPtr),
        .wv  (newEntry),
        .ra  (headPtr),
        .rv  (headEntry)
    );

endmodule
